// File: rtl/qm_pkg.sv
// Shared definitions for the multi-queue frame manager: header layout,
// descriptor format and controller state encoding.
package qm_pkg;

   localparam int unsigned LEN_W       = 12;
   localparam int unsigned HDR_MASK_LSB = 0;
   localparam int unsigned HDR_LENHI_LSB = 4;
   localparam int unsigned HDR_LENHI_W = 4;
   localparam int unsigned HDR_BYTES   = 2;
   localparam int unsigned DESC_W      = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_DROP = 3'd3,
      ST_PTR  = 3'd4
   } state_e;

   typedef struct packed {
      logic             trunc;
      logic [2:0]       rsvd;
      logic [LEN_W-1:0] wcnt;
   } desc_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; reads of an empty FIFO are
// ignored and a full FIFO accepts a write when a read happens on the same edge.
module sync_fifo #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [W-1:0]  din,
   input  logic          rd,
   output logic [W-1:0]  dout,
   output logic [AW:0]   count
);

   localparam int unsigned CW    = AW + 1;
   localparam int unsigned DEPTH = 1 << AW;

   logic [W-1:0]  mem [DEPTH];
   logic [CW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_c;
   logic [W-1:0]  dout_q, dout_d;
   logic          do_rd_c, do_wr_c;

   always_comb begin
      count_c = wptr_q - rptr_q;
      do_rd_c = rd && (count_c != '0);
      do_wr_c = wr && (!count_c[AW] || do_rd_c);
      wptr_d  = wptr_q + CW'(do_wr_c);
      rptr_d  = rptr_q + CW'(do_rd_c);
      dout_d  = do_rd_c ? mem[rptr_q[AW-1:0]] : dout_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         dout_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         dout_q <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_wr_c) mem[wptr_q[AW-1:0]] <= din;
   end

   assign dout  = dout_q;
   assign count = count_c;

endmodule

// File: rtl/qm_mq.sv
// Frame ingress manager: parses a 2-byte header, admits frames to one of NQ
// priority queues (data + descriptor FIFOs) or drops and counts them.
module qm_mq
   import qm_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned PW    = 4,
   parameter int unsigned NQ    = 4,
   parameter int unsigned DAW   = 12,
   parameter int unsigned PAW   = 5,
   parameter int unsigned BP_TH = 2578,
   localparam int unsigned QW   = (NQ > 1) ? $clog2(NQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PW-1:0]        port_id,
   input  logic                 sof,
   input  logic                 dv,
   input  logic [DW-1:0]        data,
   input  logic [QW-1:0]        prio,
   output logic [NQ-1:0]        bp,
   input  logic [NQ-1:0]        data_fifo_rd,
   output logic [NQ*DW-1:0]     data_fifo_dout,
   input  logic [NQ-1:0]        ptr_fifo_rd,
   output logic [NQ*DESC_W-1:0] ptr_fifo_dout,
   output logic [NQ-1:0]        ptr_fifo_empty,
   output logic [15:0]          drop_cnt
);

   localparam int unsigned CW = DAW + 1;
   localparam int unsigned DD = 1 << DAW;

   state_e                 state_q, state_d;
   logic [QW-1:0]          q_q, q_d;
   logic [HDR_LENHI_W-1:0] len_hi_q, len_hi_d;
   logic [LEN_W-1:0]       pay_q, pay_d, wcnt_q, wcnt_d;
   logic                   data_wr_q, data_wr_d, ptr_wr_q, ptr_wr_d;
   logic [DW-1:0]          wdata_q, wdata_d;
   desc_t                  desc_q, desc_d;
   logic [15:0]            drop_cnt_q, drop_cnt_d;

   logic [CW-1:0]          dcnt [NQ];
   logic [PAW:0]           pcnt [NQ];
   logic [NQ-1:0]          pfull;
   logic [LEN_W-1:0]       len_c, pay_c;
   logic [CW-1:0]          room_c;

   always_comb begin
      state_d    = state_q;
      q_d        = q_q;
      len_hi_d   = len_hi_q;
      pay_d      = pay_q;
      wcnt_d     = wcnt_q;
      data_wr_d  = 1'b0;
      wdata_d    = wdata_q;
      ptr_wr_d   = 1'b0;
      desc_d     = desc_q;
      drop_cnt_d = drop_cnt_q;
      len_c      = {len_hi_q, data[LEN_W-HDR_LENHI_W-1:0]};
      pay_c      = len_c - LEN_W'(HDR_BYTES);
      room_c     = CW'(DD) - dcnt[q_q];

      case (state_q)
         ST_IDLE: begin
            if (sof && ((port_id & data[HDR_MASK_LSB +: PW]) != '0)) begin
               q_d      = prio;
               len_hi_d = data[HDR_LENHI_LSB +: HDR_LENHI_W];
               state_d  = ST_LEN;
            end
         end
         ST_LEN: begin
            pay_d  = pay_c;
            wcnt_d = '0;
            // admit only if the whole payload fits and a descriptor slot exists
            if ((len_c < LEN_W'(HDR_BYTES + 1)) || (32'(pay_c) > 32'(room_c)) || pfull[q_q])
               state_d = ST_DROP;
            else
               state_d = ST_DATA;
         end
         ST_DATA: begin
            if (dv) begin
               if (wcnt_q < pay_q) begin
                  data_wr_d = 1'b1;
                  wdata_d   = data;
                  wcnt_d    = wcnt_q + LEN_W'(1);
               end
            end else begin
               ptr_wr_d = 1'b1;
               desc_d   = '{trunc: (wcnt_q < pay_q), rsvd: 3'b000, wcnt: wcnt_q};
               state_d  = ST_PTR;
            end
         end
         ST_PTR: state_d = ST_IDLE;
         ST_DROP: begin
            if (!dv) begin
               if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         q_q        <= '0;
         len_hi_q   <= '0;
         pay_q      <= '0;
         wcnt_q     <= '0;
         data_wr_q  <= 1'b0;
         wdata_q    <= '0;
         ptr_wr_q   <= 1'b0;
         desc_q     <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         q_q        <= q_d;
         len_hi_q   <= len_hi_d;
         pay_q      <= pay_d;
         wcnt_q     <= wcnt_d;
         data_wr_q  <= data_wr_d;
         wdata_q    <= wdata_d;
         ptr_wr_q   <= ptr_wr_d;
         desc_q     <= desc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   for (genvar i = 0; i < NQ; i++) begin : g_q
      sync_fifo #(.W(DW), .AW(DAW)) u_data (
         .clk   (clk),
         .rst   (rst),
         .wr    (data_wr_q && (q_q == QW'(i))),
         .din   (wdata_q),
         .rd    (data_fifo_rd[i]),
         .dout  (data_fifo_dout[i*DW +: DW]),
         .count (dcnt[i])
      );

      sync_fifo #(.W(DESC_W), .AW(PAW)) u_ptr (
         .clk   (clk),
         .rst   (rst),
         .wr    (ptr_wr_q && (q_q == QW'(i))),
         .din   (desc_q),
         .rd    (ptr_fifo_rd[i]),
         .dout  (ptr_fifo_dout[i*DESC_W +: DESC_W]),
         .count (pcnt[i])
      );

      // count never exceeds depth, so its MSB alone means full
      assign pfull[i]          = pcnt[i][PAW];
      assign ptr_fifo_empty[i] = (pcnt[i] == '0);
      assign bp[i]             = (32'(dcnt[i]) > BP_TH) || pfull[i];
   end

   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_qm_mq.sv
// Directed bench for qm_mq: vector table of single frames plus sequences for
// queue overflow, descriptor-full backpressure and mid-frame reset.
module tb_qm_mq;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 4;
   localparam int unsigned NQ = 4;
   localparam int unsigned QW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [PW-1:0]     port_id;
   logic              sof, dv;
   logic [DW-1:0]     data;
   logic [QW-1:0]     prio;
   logic [NQ-1:0]     bp, data_fifo_rd, ptr_fifo_rd, ptr_fifo_empty;
   logic [NQ*DW-1:0]  data_fifo_dout;
   logic [NQ*16-1:0]  ptr_fifo_dout;
   logic [15:0]       drop_cnt;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   qm_mq dut (
      .clk            (clk),
      .rst            (rst),
      .port_id        (port_id),
      .sof            (sof),
      .dv             (dv),
      .data           (data),
      .prio           (prio),
      .bp             (bp),
      .data_fifo_rd   (data_fifo_rd),
      .data_fifo_dout (data_fifo_dout),
      .ptr_fifo_rd    (ptr_fifo_rd),
      .ptr_fifo_dout  (ptr_fifo_dout),
      .ptr_fifo_empty (ptr_fifo_empty),
      .drop_cnt       (drop_cnt)
   );

   typedef struct {
      logic [3:0]  mask;
      logic [1:0]  pr;
      logic [11:0] len;
      int          nsend;
      bit          has_desc;
      logic [15:0] desc;
      int          nbytes;
      logic [15:0] drop;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; sof = 1'b0; dv = 1'b0; data = '0; prio = '0;
      data_fifo_rd = '0; ptr_fifo_rd = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] mask, input logic [1:0] pr,
                             input logic [11:0] len, input int nsend, input logic [7:0] seed);
      tick();
      sof = 1'b1; dv = 1'b1; data = {len[11:8], mask}; prio = pr;
      tick();
      sof = 1'b0; data = len[7:0];
      for (int k = 0; k < nsend; k++) begin
         tick();
         data = 8'(seed + 8'(k));
      end
      tick();
      dv = 1'b0; data = '0;
      repeat (3) tick();
   endtask

   task automatic pop_ptr(input int q, output logic [15:0] d);
      ptr_fifo_rd = 4'(1 << q);
      tick();
      ptr_fifo_rd = '0;
      d = ptr_fifo_dout[q*16 +: 16];
   endtask

   task automatic pop_data(input int q, output logic [7:0] d);
      data_fifo_rd = 4'(1 << q);
      tick();
      data_fifo_rd = '0;
      d = data_fifo_dout[q*DW +: DW];
   endtask

   initial begin
      logic [15:0] d16;
      logic [7:0]  d8;
      logic [7:0]  seed;
      logic [3:0]  exp_empty;

      port_id = 4'h1;
      vecs[0] = '{4'h1, 2'd2, 12'h010, 14,  1'b1, 16'h000E, 14,  16'd0};
      vecs[1] = '{4'h2, 2'd0, 12'h010, 14,  1'b0, 16'h0000, 0,   16'd0};
      vecs[2] = '{4'h1, 2'd3, 12'h010, 6,   1'b1, 16'h8006, 6,   16'd0};
      vecs[3] = '{4'h1, 2'd1, 12'h005, 7,   1'b1, 16'h0003, 3,   16'd0};
      vecs[4] = '{4'h1, 2'd0, 12'h002, 0,   1'b0, 16'h0000, 0,   16'd1};
      vecs[5] = '{4'hF, 2'd0, 12'h003, 1,   1'b1, 16'h0001, 1,   16'd1};
      vecs[6] = '{4'h1, 2'd2, 12'h105, 259, 1'b1, 16'h0103, 259, 16'd1};

      do_reset();
      check("reset bp", 32'(bp), 32'h0);
      check("reset ptr_empty", 32'(ptr_fifo_empty), 32'hF);
      check("reset ptr_dout", ptr_fifo_dout[31:0], 32'h0);
      check("reset ptr_dout_hi", ptr_fifo_dout[63:32], 32'h0);
      check("reset data_dout", data_fifo_dout, 32'h0);
      check("reset drop_cnt", 32'(drop_cnt), 32'h0);

      for (int i = 0; i < 7; i++) begin
         seed = 8'(16 * i + 1);
         send_frame(vecs[i].mask, vecs[i].pr, vecs[i].len, vecs[i].nsend, seed);
         exp_empty = vecs[i].has_desc ? (4'hF & ~4'(1 << vecs[i].pr)) : 4'hF;
         check($sformatf("v%0d ptr_empty", i), 32'(ptr_fifo_empty), 32'(exp_empty));
         check($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].drop));
         check($sformatf("v%0d bp", i), 32'(bp), 32'h0);
         if (vecs[i].has_desc) begin
            pop_ptr(int'(vecs[i].pr), d16);
            check($sformatf("v%0d desc", i), 32'(d16), 32'(vecs[i].desc));
            for (int k = 0; k < vecs[i].nbytes; k++) begin
               pop_data(int'(vecs[i].pr), d8);
               check($sformatf("v%0d byte%0d", i, k), 32'(d8), 32'(8'(seed + 8'(k))));
            end
            check($sformatf("v%0d empty_after", i), 32'(ptr_fifo_empty), 32'hF);
         end
      end

      // queue 0 nearly full of data: oversized frame dropped, small one admitted
      do_reset();
      send_frame(4'h1, 2'd0, 12'd4088, 4086, 8'h00);
      check("fill desc_present", 32'(ptr_fifo_empty), 32'hE);
      pop_ptr(0, d16);
      check("fill desc", 32'(d16), 32'h0FF6);
      check("fill bp", 32'(bp), 32'h1);
      send_frame(4'h1, 2'd0, 12'd22, 20, 8'h40);
      check("room drop_cnt", 32'(drop_cnt), 32'h1);
      check("room no_desc", 32'(ptr_fifo_empty), 32'hF);
      send_frame(4'h1, 2'd0, 12'd10, 8, 8'h80);
      check("room accept_empty", 32'(ptr_fifo_empty), 32'hE);
      pop_ptr(0, d16);
      check("room accept_desc", 32'(d16), 32'h0008);
      check("room accept_drop", 32'(drop_cnt), 32'h1);

      // descriptor FIFO 1 full: backpressure and drop until one is read
      do_reset();
      for (int n = 0; n < 32; n++) send_frame(4'h1, 2'd1, 12'd3, 1, 8'(n));
      check("pfull bp", 32'(bp), 32'h2);
      send_frame(4'h1, 2'd1, 12'd3, 1, 8'hEE);
      check("pfull drop_cnt", 32'(drop_cnt), 32'h1);
      pop_ptr(1, d16);
      check("pfull desc", 32'(d16), 32'h0001);
      check("pfull bp_release", 32'(bp), 32'h0);

      // reset during DATA aborts the frame cleanly
      do_reset();
      tick();
      sof = 1'b1; dv = 1'b1; data = 8'h01; prio = 2'd2;
      tick();
      sof = 1'b0; data = 8'h10;
      for (int k = 0; k < 5; k++) begin
         tick();
         data = 8'(8'hC0 + 8'(k));
      end
      tick();
      rst = 1'b1; dv = 1'b0; data = '0;
      tick();
      rst = 1'b0;
      check("midrst ptr_empty", 32'(ptr_fifo_empty), 32'hF);
      check("midrst bp", 32'(bp), 32'h0);
      check("midrst drop_cnt", 32'(drop_cnt), 32'h0);
      send_frame(4'h1, 2'd2, 12'd6, 4, 8'h55);
      check("postrst ptr_empty", 32'(ptr_fifo_empty), 32'hB);
      pop_ptr(2, d16);
      check("postrst desc", 32'(d16), 32'h0004);
      for (int k = 0; k < 4; k++) begin
         pop_data(2, d8);
         check($sformatf("postrst byte%0d", k), 32'(d8), 32'(8'(8'h55 + 8'(k))));
      end

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
